// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory bus for the MEM-stage load/store unit.
// The slave modport is the unit; the master modport is the pipeline plus dataMem.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  // request channel from the EX/MEM register
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // response channel
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  // word-only data memory port
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_read;
  logic              mem_write;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-only data memory.
// Byte/half/word requests become word accesses; sub-word stores are done as
// read-modify-write, loads are lane-selected and extended, and misaligned,
// reserved-size or out-of-range requests are answered with an error and never
// reach the memory.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2048
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_unit_if.slave bus
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_access_unit supports DATA_W = 32 only");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR       = 3'd1,
    S_LD_REQ   = 3'd2,
    S_LD_DATA  = 3'd3,
    S_RMW_REQ  = 3'd4,
    S_RMW_DATA = 3'd5,
    S_RMW_WR   = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  // Replace only the addressed byte/half lane of old_word; other lanes are kept bit-exact.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = old_word;
    case (size)
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = new_data[7:0];
          2'd1:    res[15:8]  = new_data[7:0];
          2'd2:    res[23:16] = new_data[7:0];
          default: res[31:24] = new_data[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = new_data[15:0];
        end else begin
          res[15:0]  = new_data[15:0];
        end
      end
      default: res = new_data;
    endcase
    return res;
  endfunction

  // Pick the addressed lane out of a memory word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merge;

  logic              w_idle;
  logic              w_req_fire;
  logic              w_req_err;
  logic [ADDR_W-1:0] w_req_widx;

  assign w_idle     = (r_state == S_IDLE);
  assign w_req_fire = bus.req_valid & w_idle;
  assign w_req_widx = bus.req_addr >> 2'd2;
  // Alignment, reserved size and range are all judged on the incoming request.
  assign w_req_err  = (bus.req_size == 2'b11)
                    | ((bus.req_size == 2'b01) & bus.req_addr[0])
                    | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                    | (w_req_widx >= ADDR_W'(MEM_DEPTH));

  // State register; reset drops straight to IDLE so any in-flight store is abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE classifies the request, the rest walk a fixed sequence back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          if (w_req_err) begin
            w_next = S_ERR;
          end else if (!bus.req_write) begin
            w_next = S_LD_REQ;
          end else if (bus.req_size == 2'b10) begin
            w_next = S_WR;
          end else begin
            w_next = S_RMW_REQ;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WR:       w_next = S_IDLE;
      S_LD_REQ:   w_next = S_LD_DATA;
      S_LD_DATA:  w_next = S_IDLE;
      S_RMW_REQ:  w_next = S_RMW_DATA;
      S_RMW_DATA: w_next = S_RMW_WR;
      S_RMW_WR:   w_next = S_IDLE;
      S_ERR:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Capture the request on transfer and build the merged word while the old word is on mem_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_merge  <= 32'd0;
    end else begin
      if (w_req_fire) begin
        r_write  <= bus.req_write;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
      if (r_state == S_RMW_DATA) begin
        r_merge <= merge_lane(bus.mem_rdata, r_wdata, r_size, r_addr[1:0]);
      end
    end
  end

  // Outputs decode from the state register only (plus registered memory data in LD_DATA).
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = 32'd0;
    bus.mem_addr   = 32'(r_addr >> 2'd2);
    case (r_state)
      S_IDLE: bus.req_ready = 1'b1;
      S_WR: begin
        bus.mem_write  = 1'b1;
        bus.mem_wdata  = r_wdata;
        bus.resp_valid = 1'b1;
      end
      S_LD_REQ: bus.mem_read = 1'b1;
      S_LD_DATA: begin
        bus.resp_valid = 1'b1;
        if (!r_write) begin
          bus.resp_rdata = load_extend(bus.mem_rdata, r_size, r_signed, r_addr[1:0]);
        end else begin
          bus.resp_rdata = 32'd0;
        end
      end
      S_RMW_REQ:  bus.mem_read = 1'b1;
      S_RMW_DATA: bus.mem_read = 1'b0;
      S_RMW_WR: begin
        bus.mem_write  = 1'b1;
        bus.mem_wdata  = r_merge;
        bus.resp_valid = 1'b1;
      end
      S_ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default: bus.req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-addressed reference memory predicts every
// response, a monitor compares responses and memory strobes as they appear.
module tb_mem_access_unit;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] widx;
    logic [31:0] wword;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] dmem [0:DEPTH-1] = '{default: 32'd0};
  logic [7:0]  ref_bytes [0:4*DEPTH-1] = '{default: 8'd0};
  int          seen_rd = 0;
  int          seen_wr = 0;
  logic [31:0] seen_addr = 32'd0;
  logic [31:0] seen_wdata = 32'd0;
  exp_t        me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // dataMem stand-in: synchronous write, registered read
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < DEPTH) dmem[bus.mem_addr[10:0]] <= bus.mem_wdata;
    if (bus.mem_read) bus.mem_rdata <= dmem[bus.mem_addr[10:0]];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: byte-level memory semantics, evaluated when the request is accepted.
  task automatic ref_model(input bit w, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int nb;
    logic [31:0] v;
    e.err    = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
               || ((a >> 2) >= DEPTH);
    e.widx   = a >> 2;
    e.rdata  = 32'd0;
    e.exp_rd = 0;
    e.exp_wr = 0;
    e.wword  = 32'd0;
    e.lat    = 1;
    e.acc_cyc = 0;
    if (!e.err) begin
      nb = 1 << sz;
      if (w) begin
        for (int i = 0; i < nb; i++) ref_bytes[a + i] = d[8*i +: 8];
        for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = ref_bytes[{e.widx[29:0], 2'b00} + i];
        e.exp_wr = 1;
        e.exp_rd = (nb < 4) ? 1 : 0;
        e.lat    = (nb < 4) ? 3 : 1;
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_bytes[a + i];
        if (sg && nb < 4 && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        e.rdata  = v;
        e.exp_rd = 1;
        e.lat    = 2;
      end
    end
  endtask

  // Monitor: count strobes, and check each response against the oldest expectation.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("strobe_in_reset", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      seen_rd = 0;
      seen_wr = 0;
    end else begin
      if (bus.mem_read) seen_rd++;
      if (bus.mem_write) begin
        seen_wr++;
        seen_wdata = bus.mem_wdata;
      end
      if (bus.mem_read || bus.mem_write) seen_addr = bus.mem_addr;
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none at cycle %0d", cyc);
        end else begin
          me = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, me.rdata);
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, me.err});
          chk("latency", cyc - me.acc_cyc, me.lat);
          chk("mem_read_count", seen_rd, me.exp_rd);
          chk("mem_write_count", seen_wr, me.exp_wr);
          if (me.exp_rd + me.exp_wr > 0) chk("mem_addr", seen_addr, me.widx);
          if (me.exp_wr > 0) chk("mem_wdata", seen_wdata, me.wword);
        end
        seen_rd = 0;
        seen_wr = 0;
      end else begin
        chk("idle_rdata", bus.resp_rdata, 32'd0);
        chk("idle_err", {31'd0, bus.resp_err}, 32'd0);
      end
    end
  end

  // Present one request (called at a negedge); returns at the negedge after acceptance.
  task automatic do_req(input bit w, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] d, input bit hold);
    exp_t e;
    int n;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      bus.req_valid = 1'b0;
    end else begin
      ref_model(w, sz, sg, a, d, e);
      e.acc_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL resp_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [7:0]  saved [4];
  logic [1:0]  rsz;
  logic [31:0] raddr;
  int          rr;

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    // word store then load
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0); wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b0);        wait_idle();
    // byte read-modify-write
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344, 1'b0); wait_idle();
    do_req(1'b1, 2'd0, 1'b0, 32'h81, 32'h123456AA, 1'b0); wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 1'b0);        wait_idle();
    // extension cases
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h8000F0FF, 1'b0); wait_idle();
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, 1'b0);        wait_idle();
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, 1'b0);        wait_idle();
    do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'd0, 1'b0);        wait_idle();
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, 1'b0);        wait_idle();
    // errors and range boundary
    do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'd0, 1'b0);          wait_idle();
    do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'h5A5A5A5A, 1'b0);   wait_idle();
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 1'b0);          wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h2000, 32'd0, 1'b0);       wait_idle();
    do_req(1'b1, 2'd2, 1'b0, 32'h1FFC, 32'hCAFEF00D, 1'b0); wait_idle();
    do_req(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'd0, 1'b0);       wait_idle();
    do_req(1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234, 1'b0);    wait_idle();

    // reset during RMW_DATA of a byte store aborts it
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h55667788, 1'b0); wait_idle();
    for (int i = 0; i < 4; i++) saved[i] = ref_bytes[32'h200 + i];
    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'h00000099, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) ref_bytes[32'h200 + i] = saved[i];
    #1;
    chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, bus.req_ready}, 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b0); wait_idle();

    // back-to-back word stores with req_valid held high
    do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hA0000001, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h304, 32'hA0000002, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h308, 32'hA0000003, 1'b1);
    do_req(1'b1, 2'd2, 1'b0, 32'h30C, 32'hA0000004, 1'b0);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 2'd2, 1'b0, 32'h300 + 32'(4*i), 32'd0, 1'b0);
      wait_idle();
    end

    // randomized traffic over a small window plus occasional far addresses
    for (int k = 0; k < 400; k++) begin
      rr = $urandom_range(0, 7);
      rsz = (rr < 2) ? 2'd0 : (rr < 4) ? 2'd1 : (rr < 7) ? 2'd2 : 2'd3;
      raddr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0 && rsz == 2'd2) raddr[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0 && rsz == 2'd1) raddr[0] = 1'b0;
      do_req(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), raddr, $urandom,
             ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end
    bus.req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
